// File: rtl/mem_arbiter_t_pkg.sv
// Shared CPU package: memory address width, byte width and the
// enums used by the shared memory-port arbiter.
// Latency/backpressure: n/a (types and constants only).
`ifndef BYTE
`define BYTE 8
`endif

package mem_arbiter_t_pkg;

   localparam int MEM_ADDR_SIZE = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_FE = 2'd1,
      BUSY_DT = 2'd2
   } mem_arb_state_t;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DATA  = 1'b1
   } mem_req_id_t;

endpackage

// File: rtl/mem_arbiter_t.sv
// Purpose: round-robin arbiter sharing one memory port between the fetch
//          unit and the data unit, with wait-cycle timeout and fetch flush.
// Latency: grant is combinational in IDLE; response pulses one cycle after
//          mem_valid_i (zero-wait memory gives one transaction per 2 cycles).
// Backpressure: requesters hold req high until gnt; no grant while busy.
// Ports: clk_i/rst_i (async active-high); fe_* fetch request/response;
//        dt_* data request/response; err_o timeout flag alongside rvalid;
//        mem_* the single shared memory port.
`ifndef BYTE
`define BYTE 8
`endif

module mem_arbiter_t
   import mem_arbiter_t_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fe_req_i,
   input  logic [MEM_ADDR_SIZE-1:0] fe_addr_i,
   input  logic                     fe_flush_i,
   output logic                     fe_gnt_o,
   output logic                     fe_rvalid_o,
   output logic [3*`BYTE-1:0]       fe_rdata_o,
   input  logic                     dt_req_i,
   input  logic                     dt_we_i,
   input  logic [MEM_ADDR_SIZE-1:0] dt_addr_i,
   input  logic [`BYTE-1:0]         dt_wdata_i,
   output logic                     dt_gnt_o,
   output logic                     dt_rvalid_o,
   output logic [`BYTE-1:0]         dt_rdata_o,
   output logic                     err_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
   output logic [`BYTE-1:0]         mem_wdata_o,
   input  logic [3*`BYTE-1:0]       mem_rdata_i,
   input  logic                     mem_valid_i
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   mem_arb_state_t            r_state;
   mem_arb_state_t            w_state_nxt;
   mem_req_id_t               r_last_grant;
   logic [CW-1:0]             r_wait_cnt;
   logic                      r_drop;
   logic [MEM_ADDR_SIZE-1:0]  r_addr;
   logic                      r_we;
   logic [`BYTE-1:0]          r_wdata;
   logic                      r_fe_rvalid;
   logic                      r_dt_rvalid;
   logic                      r_err;
   logic [3*`BYTE-1:0]        r_fe_rdata;
   logic [`BYTE-1:0]          r_dt_rdata;

   logic w_fe_cand;
   logic w_dt_cand;
   logic w_pick_fe;
   logic w_pick_dt;
   logic w_busy;
   logic w_timeout;
   logic w_done;
   logic w_fe_drop;

   // A flush in IDLE removes fetch from contention for that cycle.
   assign w_fe_cand = fe_req_i & ~fe_flush_i;
   assign w_dt_cand = dt_req_i;
   // On a tie the requester not granted last wins.
   assign w_pick_dt = w_dt_cand & (~w_fe_cand | (r_last_grant == REQ_FETCH));
   assign w_pick_fe = w_fe_cand & ~w_pick_dt;

   assign w_busy    = (r_state != IDLE);
   // Timeout fires in the busy cycle where the wait count would reach MAX_WAIT.
   assign w_timeout = w_busy & ~mem_valid_i & (r_wait_cnt == CW'(MAX_WAIT - 1));
   assign w_done    = w_busy & (mem_valid_i | w_timeout);
   // A flush coincident with completion still drops the response.
   assign w_fe_drop = r_drop | fe_flush_i;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_pick_dt)      w_state_nxt = BUSY_DT;
            else if (w_pick_fe) w_state_nxt = BUSY_FE;
         end
         BUSY_FE, BUSY_DT: begin
            if (w_done) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      fe_gnt_o  = 1'b0;
      dt_gnt_o  = 1'b0;
      mem_req_o = 1'b0;
      if (!rst_i) begin
         fe_gnt_o  = (r_state == IDLE) & w_pick_fe;
         dt_gnt_o  = (r_state == IDLE) & w_pick_dt;
         mem_req_o = w_busy;
      end
   end

   // Request latch, wait counter and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_grant <= REQ_FETCH;
         r_wait_cnt   <= '0;
         r_drop       <= 1'b0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_fe_rvalid  <= 1'b0;
         r_dt_rvalid  <= 1'b0;
         r_err        <= 1'b0;
         r_fe_rdata   <= '0;
         r_dt_rdata   <= '0;
      end else begin
         r_fe_rvalid <= 1'b0;
         r_dt_rvalid <= 1'b0;
         r_err       <= 1'b0;

         if (w_busy && !mem_valid_i && (r_wait_cnt != CW'(MAX_WAIT)))
            r_wait_cnt <= r_wait_cnt + CW'(1);

         case (r_state)
            IDLE: begin
               if (w_pick_dt || w_pick_fe) begin
                  r_addr       <= w_pick_dt ? dt_addr_i : fe_addr_i;
                  r_we         <= w_pick_dt & dt_we_i;
                  r_last_grant <= w_pick_dt ? REQ_DATA : REQ_FETCH;
                  r_wait_cnt   <= '0;
                  r_drop       <= 1'b0;
                  if (w_pick_dt) r_wdata <= dt_wdata_i;
               end
            end
            BUSY_FE: begin
               if (fe_flush_i) r_drop <= 1'b1;
               if (w_done && !w_fe_drop) begin
                  r_fe_rvalid <= 1'b1;
                  r_err       <= w_timeout;
                  r_fe_rdata  <= w_timeout ? '0 : mem_rdata_i;
               end
            end
            BUSY_DT: begin
               if (w_done) begin
                  r_dt_rvalid <= 1'b1;
                  r_err       <= w_timeout;
                  // Writes are acknowledged only; read data is left untouched.
                  if (!r_we) r_dt_rdata <= w_timeout ? '0 : mem_rdata_i[`BYTE-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign fe_rvalid_o = r_fe_rvalid;
   assign dt_rvalid_o = r_dt_rvalid;
   assign err_o       = r_err;
   assign fe_rdata_o  = r_fe_rdata;
   assign dt_rdata_o  = r_dt_rdata;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_arbiter_t.sv
// Directed bench for mem_arbiter_t: reset, zero-wait fetch, round-robin,
// waited write, timeout read, fetch flush and mid-transaction reset.
module tb_mem_arbiter_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        fe_req_i = 1'b0;
   logic [15:0] fe_addr_i = '0;
   logic        fe_flush_i = 1'b0;
   logic        fe_gnt_o;
   logic        fe_rvalid_o;
   logic [23:0] fe_rdata_o;
   logic        dt_req_i = 1'b0;
   logic        dt_we_i = 1'b0;
   logic [15:0] dt_addr_i = '0;
   logic [7:0]  dt_wdata_i = '0;
   logic        dt_gnt_o;
   logic        dt_rvalid_o;
   logic [7:0]  dt_rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic [23:0] mem_rdata_i = '0;
   logic        mem_valid_i = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter_t #(.MAX_WAIT(15)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fe_req_i(fe_req_i), .fe_addr_i(fe_addr_i), .fe_flush_i(fe_flush_i),
      .fe_gnt_o(fe_gnt_o), .fe_rvalid_o(fe_rvalid_o), .fe_rdata_o(fe_rdata_o),
      .dt_req_i(dt_req_i), .dt_we_i(dt_we_i), .dt_addr_i(dt_addr_i),
      .dt_wdata_i(dt_wdata_i), .dt_gnt_o(dt_gnt_o), .dt_rvalid_o(dt_rvalid_o),
      .dt_rdata_o(dt_rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // ---------------- reset state, requests pending during reset
      fe_req_i = 1'b1;
      dt_req_i = 1'b1;
      step(); step();
      #1;
      chk("rst_fe_gnt", fe_gnt_o, 0);
      chk("rst_dt_gnt", dt_gnt_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_rvalid_err", {fe_rvalid_o, dt_rvalid_o, err_o}, 0);
      chk("rst_rdata", {fe_rdata_o, dt_rdata_o}, 0);
      fe_req_i = 1'b0;
      dt_req_i = 1'b0;
      step();
      rst_i = 1'b0;
      step();

      // ---------------- zero-wait fetch at 0x8000
      fe_req_i = 1'b1; fe_addr_i = 16'h8000; #1;
      chk("f0_fe_gnt", fe_gnt_o, 1);
      chk("f0_dt_gnt", dt_gnt_o, 0);
      step();
      fe_req_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 24'hA90102; #1;
      chk("f1_mem_req", mem_req_o, 1);
      chk("f1_mem_addr", mem_addr_o, 16'h8000);
      chk("f1_mem_we", mem_we_o, 0);
      chk("f1_no_rvalid", fe_rvalid_o, 0);
      step();
      mem_valid_i = 1'b0; #1;
      chk("f2_fe_rvalid", fe_rvalid_o, 1);
      chk("f2_fe_rdata", fe_rdata_o, 24'hA90102);
      chk("f2_err", err_o, 0);
      chk("f2_mem_req", mem_req_o, 0);
      step(); #1;
      chk("f3_rvalid_pulse", fe_rvalid_o, 0);
      chk("f3_rdata_hold", fe_rdata_o, 24'hA90102);

      // ---------------- round-robin with both requests held
      fe_req_i = 1'b1; fe_addr_i = 16'h8010;
      dt_req_i = 1'b1; dt_we_i = 1'b0; dt_addr_i = 16'h0100; #1;
      for (int i = 0; i < 4; i++) begin
         logic dexp;
         dexp = (i % 2 == 0);
         chk("rr_dt_gnt", dt_gnt_o, dexp);
         chk("rr_fe_gnt", fe_gnt_o, !dexp);
         step();
         mem_valid_i = 1'b1;
         mem_rdata_i = {8'hAB, 8'hCD, 8'(8'h10 + i)};
         if (i == 3) begin fe_req_i = 1'b0; dt_req_i = 1'b0; end
         #1;
         chk("rr_busy_no_gnt", {fe_gnt_o, dt_gnt_o}, 0);
         chk("rr_mem_addr", mem_addr_o, dexp ? 16'h0100 : 16'h8010);
         step();
         mem_valid_i = 1'b0; #1;
         if (dexp) begin
            chk("rr_dt_rvalid", {dt_rvalid_o, fe_rvalid_o}, 2'b10);
            chk("rr_dt_rdata", dt_rdata_o, 8'h10 + i);
         end else begin
            chk("rr_fe_rvalid", {dt_rvalid_o, fe_rvalid_o}, 2'b01);
            chk("rr_fe_rdata", fe_rdata_o, {8'hAB, 8'hCD, 8'(8'h10 + i)});
         end
      end
      chk("rr_end_no_gnt", {fe_gnt_o, dt_gnt_o}, 0);

      // ---------------- data write, 3 wait cycles
      step();
      dt_req_i = 1'b1; dt_we_i = 1'b1; dt_addr_i = 16'h0200; dt_wdata_i = 8'h55; #1;
      chk("w_dt_gnt", dt_gnt_o, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         dt_req_i = 1'b0; dt_wdata_i = 8'h00;
         mem_valid_i = (k == 3); mem_rdata_i = 24'hFFFFFF; #1;
         chk("w_mem_req", mem_req_o, 1);
         chk("w_mem_we", mem_we_o, 1);
         chk("w_mem_wdata", mem_wdata_o, 8'h55);
         chk("w_mem_addr", mem_addr_o, 16'h0200);
         chk("w_no_rvalid", dt_rvalid_o, 0);
      end
      step();
      mem_valid_i = 1'b0; #1;
      chk("w_dt_ack", dt_rvalid_o, 1);
      chk("w_dt_rdata_kept", dt_rdata_o, 8'h12);
      chk("w_err", err_o, 0);

      // ---------------- data read timeout (memory never answers)
      step();
      dt_req_i = 1'b1; dt_we_i = 1'b0; dt_addr_i = 16'h0300; #1;
      chk("t_dt_gnt", dt_gnt_o, 1);
      for (int k = 0; k < 15; k++) begin
         step();
         dt_req_i = 1'b0; #1;
         chk("t_busy_mem_req", mem_req_o, 1);
         chk("t_busy_no_rvalid", dt_rvalid_o, 0);
      end
      step(); #1;
      chk("t_dt_rvalid", dt_rvalid_o, 1);
      chk("t_err", err_o, 1);
      chk("t_dt_rdata", dt_rdata_o, 8'h00);
      chk("t_idle", mem_req_o, 0);
      chk("t_fe_rvalid", fe_rvalid_o, 0);
      step(); #1;
      chk("t_err_pulse", err_o, 0);

      // ---------------- flush during BUSY_FE, memory completes later
      fe_req_i = 1'b1; fe_addr_i = 16'h8100; #1;
      chk("fl_gnt", fe_gnt_o, 1);
      step();
      fe_req_i = 1'b0; fe_flush_i = 1'b1; #1;
      chk("fl_mem_req", mem_req_o, 1);
      step();
      fe_flush_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 24'h123456; #1;
      chk("fl_still_busy", mem_req_o, 1);
      step();
      mem_valid_i = 1'b0; #1;
      chk("fl_no_rvalid", fe_rvalid_o, 0);
      chk("fl_no_err", err_o, 0);
      chk("fl_rdata_hold", fe_rdata_o, 24'hABCD13);
      chk("fl_idle", mem_req_o, 0);
      // flush in IDLE blocks the fetch grant for that cycle
      fe_req_i = 1'b1; fe_flush_i = 1'b1; #1;
      chk("fl_idle_no_gnt", fe_gnt_o, 0);
      step();
      fe_flush_i = 1'b0; #1;
      chk("fl_regrant", fe_gnt_o, 1);
      // flush coincident with mem_valid_i
      step();
      fe_req_i = 1'b0; fe_flush_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 24'h654321; #1;
      chk("fc_mem_req", mem_req_o, 1);
      step();
      fe_flush_i = 1'b0; mem_valid_i = 1'b0;
      fe_req_i = 1'b1; fe_addr_i = 16'h8200; #1;
      chk("fc_no_rvalid", fe_rvalid_o, 0);
      chk("fc_rdata_hold", fe_rdata_o, 24'hABCD13);
      chk("fc_next_gnt", fe_gnt_o, 1);
      step();
      fe_req_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 24'h0A0B0C; #1;
      chk("fc_next_addr", mem_addr_o, 16'h8200);
      step();
      mem_valid_i = 1'b0; #1;
      chk("fc_next_rvalid", fe_rvalid_o, 1);
      chk("fc_next_rdata", fe_rdata_o, 24'h0A0B0C);

      // ---------------- reset in BUSY_DT
      step();
      dt_req_i = 1'b1; dt_we_i = 1'b1; dt_addr_i = 16'h0400; dt_wdata_i = 8'hAA; #1;
      chk("r_dt_gnt", dt_gnt_o, 1);
      step();
      dt_req_i = 1'b0; #1;
      chk("r_busy", {mem_req_o, mem_we_o}, 2'b11);
      rst_i = 1'b1; #1;
      chk("r_mem_req", mem_req_o, 0);
      chk("r_mem_port", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
      chk("r_rdata", {fe_rdata_o, dt_rdata_o}, 0);
      chk("r_pulses", {fe_rvalid_o, dt_rvalid_o, err_o, fe_gnt_o, dt_gnt_o}, 0);
      step();
      rst_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 24'h777777; #1;
      chk("r_idle_ignore_valid", mem_req_o, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         mem_valid_i = 1'b0; #1;
         chk("r_no_dt_rvalid", {dt_rvalid_o, err_o}, 0);
         chk("r_dt_rdata_zero", dt_rdata_o, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
